keypad_key_filter: RTL and testbench
====================================

# keypad_key_filter

Parametrised key filter between the keypad code decoder and the display/entry logic. It does the following:
- Debounces both press and release of a single key.
- Locks out additional keys while one is held.
- Freezes the scanner while a key is active.
- Optionally generates typematic auto-repeat pulses.

It supersedes the fixed 4-bit, press-only debouncer.

## Interface
Parameters:
- CODE_W, 4: key code width. All-zero code means no key or multi-key (invalid).
- DEBOUNCE_CYCLES, 60000: stable cycles required to accept a press (≥1; 20 ms at 3 MHz).
- RELEASE_CYCLES, 30000: absent cycles required to accept a release (≥1).
- REPEAT_DELAY, 1500000: HELD cycles before the first repeat pulse (≥1).
- REPEAT_RATE, 300000: cycles between subsequent repeat pulses (≥1).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- key_code  in  CODE_W  decoded code from the decoder.
- key_detected  in  1  scanner reports any key down.
- repeat_en  in  1  runtime auto-repeat enable, sampled every cycle.
- key_valid  out  1  one-cycle strobe: accepted press or repeat.
- debounced_key  out  CODE_W  latched accepted code.
- key_held  out  1  high in HELD and RELEASE_DB.
- key_released  out  1  one-cycle strobe on accepted release.
- scan_stop  out  1  freeze scanner; high in every state except IDLE.

## Operation
"Present" means key_detected=1 and key_code≠0.

States and transitions:
- IDLE: if present, go to PRESS_DB, latch key_code into l_key, clear db_cnt.
- PRESS_DB:
  - Absent, or key_code≠l_key: return to IDLE. No strobe.
  - Else if db_cnt==DEBOUNCE_CYCLES-1: go to HELD, pulse key_valid, load debounced_key←l_key, clear rpt_cnt, set rpt_phase=DELAY.
  - Else db_cnt++.
- HELD:
  - Absent: go to RELEASE_DB, clear db_cnt.
  - A different nonzero code is ignored (lockout); it is not treated as absent.
  - Repeat: only when repeat_en=1. If rpt_cnt==limit-1, where limit=REPEAT_DELAY for phase DELAY and REPEAT_RATE for phase RATE: pulse key_valid, rpt_cnt←0, rpt_phase←RATE. Else rpt_cnt++.
  - repeat_en=0: rpt_cnt and rpt_phase hold.
- RELEASE_DB:
  - Present with key_code==l_key: go back to HELD. No strobe; rpt_cnt and rpt_phase keep their values.
  - Present with a different code: counts as absent.
  - When db_cnt==RELEASE_CYCLES-1: go to IDLE and pulse key_released. Else db_cnt++.
  - rpt_cnt is frozen in this state.
- Illegal state encoding: go to IDLE.

Output behaviour:
- debounced_key keeps its value after release until the next accepted press.
- key_valid and key_released are registered and never high in the same cycle.

Width rules:
- db_cnt width = clog2(max(DEBOUNCE_CYCLES, RELEASE_CYCLES)).
- rpt_cnt width = clog2(max(REPEAT_DELAY, REPEAT_RATE)).
- Counters never wrap: comparison with limit-1 precedes increment.

## Timing
- Reset values: state=IDLE; key_valid, key_held, key_released and scan_stop =0; debounced_key, l_key, db_cnt and rpt_cnt =0; rpt_phase=DELAY.
- Reset is asynchronous and effective mid-operation. No strobe is emitted on or after reset.
- Edge numbering: edge 1 is the first clk edge sampling a present key from IDLE.
- Press strobe:
  - key_valid is high for exactly the cycle after edge DEBOUNCE_CYCLES+1, provided the key is stable through that edge.
  - key_held rises at the same edge.
- Repeat strobes, with repeat_en held high and no release: after edges DEBOUNCE_CYCLES+1+REPEAT_DELAY+n·REPEAT_RATE, n≥0.
- Release: with the key absent from edge R, key_released is high for the cycle after edge R+RELEASE_CYCLES. key_held and scan_stop fall at that same edge.
- A glitch shorter than RELEASE_CYCLES while HELD produces no strobe. key_held stays high throughout.
- Code change during PRESS_DB restarts debounce via IDLE: back in IDLE one edge later, re-entering PRESS_DB on the next edge if present.

## Structure
- Shared package keypad_pkg holds:
  - the state enum kf_state_t (IDLE, PRESS_DB, HELD, RELEASE_DB);
  - the rpt_phase_t enum;
  - default timing localparams for 3 MHz.
- One module, no sub-modules. Counters and FSM are in a single always_ff; output decode is registered.

## Test plan
- CODE_W=4, DEBOUNCE_CYCLES=8, RELEASE_CYCLES=4, repeat_en=0. Hold code 4'h5 for 30 cycles, then release. Expected:
  - key_valid is one pulse after edge 9, debounced_key=5;
  - key_released is one pulse 4 edges after release;
  - scan_stop is high from edge 1 to release.
- Bounce: code 4'h3 toggling present/absent every 3 cycles for 40 cycles, then stable. Expected: exactly one key_valid, 9 edges after the last rising toggle.
- Lockout: hold 4'h2; after acceptance, switch key_code to 4'h7 for 10 cycles, then back to 4'h2. Expected: no key_valid, no key_released, debounced_key stays 2.
- Repeat with REPEAT_DELAY=20, REPEAT_RATE=5, repeat_en=1, holding 4'hA. Expected:
  - key_valid at edges 9, 29, 34, 39;
  - dropping repeat_en at edge 36 suppresses the edge-39 pulse.
- Release glitch: 2-cycle absence while HELD (RELEASE_CYCLES=4). Expected: no key_released, key_held stays 1, repeat timing resumes without reset.
- Reset: assert rst_n=0 mid-PRESS_DB and mid-HELD. Expected: all outputs 0 asynchronously, and no strobe within the first DEBOUNCE_CYCLES edges after deassertion.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and 3 MHz timing defaults for the keypad key filter.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kf_state_t;

  typedef enum logic {
    DELAY = 1'b0,
    RATE  = 1'b1
  } rpt_phase_t;

  localparam int DEF_DEBOUNCE_CYCLES = 60000;    // 20 ms
  localparam int DEF_RELEASE_CYCLES  = 30000;    // 10 ms
  localparam int DEF_REPEAT_DELAY    = 1500000;  // 500 ms
  localparam int DEF_REPEAT_RATE     = 300000;   // 100 ms

  // Counter width able to hold max(a,b)-1; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/keypad_key_filter.sv
// Press/release debouncer with multi-key lockout, scanner freeze and
// optional typematic auto-repeat for a single keypad key.
module keypad_key_filter
  import keypad_pkg::*;
#(
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RELEASE_CYCLES  = DEF_RELEASE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_detected,
  input  logic              repeat_en,
  output logic              key_valid,
  output logic [CODE_W-1:0] debounced_key,
  output logic              key_held,
  output logic              key_released,
  output logic              scan_stop
);

  localparam int DBW = cnt_width(DEBOUNCE_CYCLES, RELEASE_CYCLES);
  localparam int RPW = cnt_width(REPEAT_DELAY, REPEAT_RATE);
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] REL_LAST = DBW'(RELEASE_CYCLES - 1);
  localparam logic [RPW-1:0] RD_LAST  = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RR_LAST  = RPW'(REPEAT_RATE - 1);

  kf_state_t         state, state_nx;
  rpt_phase_t        rpt_phase, phase_nx;
  logic [CODE_W-1:0] l_key, l_key_nx, dkey_nx;
  logic [DBW-1:0]    db_cnt, db_nx;
  logic [RPW-1:0]    rpt_cnt, rpt_nx, rpt_last;
  logic              present, same_key, valid_nx, rel_nx;

  assign present  = key_detected && (key_code != '0);
  assign same_key = present && (key_code == l_key);
  assign rpt_last = (rpt_phase == DELAY) ? RD_LAST : RR_LAST;

  always_comb begin
    state_nx = state;
    phase_nx = rpt_phase;
    l_key_nx = l_key;
    dkey_nx  = debounced_key;
    db_nx    = db_cnt;
    rpt_nx   = rpt_cnt;
    valid_nx = 1'b0;
    rel_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (present) begin
          state_nx = PRESS_DB;
          l_key_nx = key_code;
          db_nx    = '0;
        end
      end
      PRESS_DB: begin
        if (!same_key) begin
          state_nx = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nx = HELD;
          valid_nx = 1'b1;
          dkey_nx  = l_key;
          rpt_nx   = '0;
          phase_nx = DELAY;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      HELD: begin
        // Any other nonzero code is a second key: locked out, still "held".
        if (!present) begin
          state_nx = RELEASE_DB;
          db_nx    = '0;
        end else if (repeat_en) begin
          if (rpt_cnt == rpt_last) begin
            valid_nx = 1'b1;
            rpt_nx   = '0;
            phase_nx = RATE;
          end else begin
            rpt_nx = rpt_cnt + 1'b1;
          end
        end
      end
      RELEASE_DB: begin
        if (same_key) begin
          state_nx = HELD;
        end else if (db_cnt == REL_LAST) begin
          state_nx = IDLE;
          rel_nx   = 1'b1;
        end else begin
          db_nx = db_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rpt_phase     <= DELAY;
      l_key         <= '0;
      debounced_key <= '0;
      db_cnt        <= '0;
      rpt_cnt       <= '0;
      key_valid     <= 1'b0;
      key_released  <= 1'b0;
      key_held      <= 1'b0;
      scan_stop     <= 1'b0;
    end else begin
      state         <= state_nx;
      rpt_phase     <= phase_nx;
      l_key         <= l_key_nx;
      debounced_key <= dkey_nx;
      db_cnt        <= db_nx;
      rpt_cnt       <= rpt_nx;
      key_valid     <= valid_nx;
      key_released  <= rel_nx;
      key_held      <= (state_nx == HELD) || (state_nx == RELEASE_DB);
      scan_stop     <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_key_filter.sv
// Randomised and directed bench for keypad_key_filter with a timestamp-based
// reference model and a strobe scoreboard.
module tb_keypad_key_filter;

  localparam int CODE_W = 4;
  localparam int DB     = 8;
  localparam int RC     = 4;
  localparam int RD     = 20;
  localparam int RR     = 5;
  localparam int EW     = 16 + 1 + CODE_W;  // {edge, is_release, code}

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CODE_W-1:0] key_code = '0;
  logic              key_detected = 1'b0;
  logic              repeat_en = 1'b0;
  logic              key_valid, key_held, key_released, scan_stop;
  logic [CODE_W-1:0] debounced_key;

  int tests = 0;
  int fails = 0;

  keypad_key_filter #(
    .CODE_W(CODE_W), .DEBOUNCE_CYCLES(DB), .RELEASE_CYCLES(RC),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_detected(key_detected),
    .repeat_en(repeat_en), .key_valid(key_valid), .debounced_key(debounced_key),
    .key_held(key_held), .key_released(key_released), .scan_stop(scan_stop)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 pressing, 2 held, 3 releasing. Timing is tracked as the
  // edge number at which the phase began; repeats from the total count of
  // repeat-enabled held edges since acceptance.
  logic [EW-1:0]     exp_q[$];
  int                cyc = 0;
  int                m_mode = 0;
  int                m_start = 0;
  int                m_active = 0;
  logic [CODE_W-1:0] m_lkey = '0;
  logic [CODE_W-1:0] m_dkey = '0;

  always @(posedge clk or negedge rst_n) begin
    logic pres;
    if (!rst_n) begin
      m_mode = 0; m_start = 0; m_active = 0; m_lkey = '0; m_dkey = '0;
      exp_q.delete();
    end else begin
      cyc++;
      pres = key_detected && (key_code != 0);
      case (m_mode)
        0: if (pres) begin m_mode = 1; m_start = cyc; m_lkey = key_code; end
        1: begin
          if (!(pres && key_code == m_lkey)) m_mode = 0;
          else if (cyc - m_start == DB) begin
            m_mode = 2; m_dkey = m_lkey; m_active = 0;
            exp_q.push_back({cyc[15:0], 1'b0, m_dkey});
          end
        end
        2: begin
          if (!pres) begin m_mode = 3; m_start = cyc; end
          else if (repeat_en) begin
            m_active++;
            if (m_active >= RD && (m_active - RD) % RR == 0)
              exp_q.push_back({cyc[15:0], 1'b0, m_dkey});
          end
        end
        default: begin
          if (pres && key_code == m_lkey) m_mode = 2;
          else if (cyc - m_start == RC) begin
            m_mode = 0;
            exp_q.push_back({cyc[15:0], 1'b1, m_dkey});
          end
        end
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n) begin
      tests++;
      if (key_valid && key_released) begin
        fails++;
        $display("FAIL strobe_overlap: key_valid=1 key_released=1 at edge %0d, required not both", cyc);
      end
      if (key_valid || key_released) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: valid=%0b released=%0b at edge %0d, required none",
                   key_valid, key_released, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e != {cyc[15:0], key_released, debounced_key}) begin
            fails++;
            $display("FAIL strobe: got edge=%0d rel=%0b key=%h, required edge=%0d rel=%0b key=%h",
                     cyc, key_released, debounced_key, e[EW-1:CODE_W+1], e[CODE_W], e[CODE_W-1:0]);
          end
        end
      end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1:CODE_W+1]) <= cyc) begin
        e = exp_q.pop_front();
        fails++;
        $display("FAIL missed_strobe: no strobe at edge %0d, required rel=%0b key=%h at edge %0d",
                 cyc, e[CODE_W], e[CODE_W-1:0], e[EW-1:CODE_W+1]);
      end
      if (key_held != (m_mode >= 2) || scan_stop != (m_mode != 0) || debounced_key != m_dkey) begin
        fails++;
        $display("FAIL levels at edge %0d: held=%0b scan_stop=%0b key=%h, required held=%0b scan_stop=%0b key=%h",
                 cyc, key_held, scan_stop, debounced_key, (m_mode >= 2), (m_mode != 0), m_dkey);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [CODE_W-1:0] code, input logic det, input int n);
    key_code = code;
    key_detected = det;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({key_valid, key_held, key_released, scan_stop, debounced_key} != '0) begin
      fails++;
      $display("FAIL %s: valid=%0b held=%0b rel=%0b scan_stop=%0b key=%h, required all 0",
               name, key_valid, key_held, key_released, scan_stop, debounced_key);
    end
  endtask

  // Asynchronous reset between edges while a key stays down, then ensure
  // no strobe during the first DB edges after deassertion.
  task automatic mid_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check_zero(name);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DB; i++) begin
      @(negedge clk);
      tests++;
      if (key_valid || key_released) begin
        fails++;
        $display("FAIL %s_post: strobe %0d edges after reset, required none", name, i + 1);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 check_zero("reset_values");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(4'h0, 1'b0, 3);

    // basic press/hold/release
    drive(4'h5, 1'b1, 30);
    drive(4'h0, 1'b0, 10);

    // bounce then stable
    for (int i = 0; i < 40; i += 3) drive(4'h3, ((i / 3) % 2) == 0, 3);
    drive(4'h3, 1'b1, 20);
    drive(4'h0, 1'b0, 10);

    // lockout of a second key
    drive(4'h2, 1'b1, 12);
    drive(4'h7, 1'b1, 10);
    drive(4'h2, 1'b1, 5);
    drive(4'h0, 1'b0, 10);

    // auto-repeat, dropping repeat_en after edge-36-equivalent
    repeat_en = 1'b1;
    drive(4'hA, 1'b1, 35);
    repeat_en = 1'b0;
    drive(4'hA, 1'b1, 10);
    drive(4'h0, 1'b0, 10);

    // short release glitch with repeat running
    repeat_en = 1'b1;
    drive(4'h9, 1'b1, 24);
    drive(4'h0, 1'b0, 2);
    drive(4'h9, 1'b1, 30);
    drive(4'h0, 1'b1, 8);   // detected but zero code counts as absent
    repeat_en = 1'b0;

    // reset mid-press and mid-held
    drive(4'h4, 1'b1, 4);
    mid_reset("reset_mid_press");
    drive(4'h4, 1'b1, 15);
    mid_reset("reset_mid_held");
    drive(4'h0, 1'b0, 10);

    // randomised segments
    for (int s = 0; s < 300; s++) begin
      repeat_en = ($urandom_range(0, 3) != 0);
      drive(4'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
    end
    drive(4'h0, 1'b0, 12);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d strobes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
